// File: rtl/dl_reset_ctrl_pkg.sv
// dl_reset_ctrl_pkg
// Shared definitions for the download/reset controller: the FSM state
// enum and the HPS transfer index constants.
// Optional feature macro: WAVE_DL_EN (adds the WAVE_LOAD state).
package dl_reset_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_ROM_LOAD,
`ifdef WAVE_DL_EN
        ST_WAVE_LOAD,
`endif
        ST_HOLD,
        ST_RUN
    } state_t;

    localparam logic [7:0] IDX_ROM  = 8'd0;
    localparam logic [7:0] IDX_WAVE = 8'd2;
    localparam logic [7:0] IDX_DIP  = 8'd254;

endpackage

// File: rtl/dl_reset_ctrl_if.sv
// dl_reset_ctrl_if
// HPS ioctl transfer bus.
//   ioctl_download : transfer active
//   ioctl_index    : transfer index (0 ROM, 2 wave, 254 DIP)
//   ioctl_wr       : one-cycle byte strobe
//   ioctl_addr     : byte address
//   ioctl_dout     : byte data
// master = HPS side (drives), slave = controller (receives).
interface dl_reset_ctrl_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
    );
endinterface

// File: rtl/dl_reset_ctrl_reset_stretch.sv
// reset_stretch
// Down-counter that stretches the core reset. i_load reloads the count
// with HOLD_CYCLES-1; otherwise it decrements to 0 and stays there.
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset (count -> 0)
//   i_load : reload the counter
//   o_done : counter is at 0
module reset_stretch #(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_done
);

    localparam int unsigned    CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]  LOAD_VAL = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/dl_reset_ctrl.sv
// dl_reset_ctrl
// Routes HPS downloads (ROM, wave samples, DIP bytes) to their targets and
// holds the game core in reset until the required images are loaded.
//   clk_sys      : system clock (only clock)
//   reset        : asynchronous active-high reset
//   ioctl        : HPS transfer bus (slave modport)
//   user_reset   : OSD reset / user button
//   dl_*         : ROM write port to the core (registered, 1-cycle latency)
//   wave_*       : wave-sample write port to SDRAM (registered)
//   dip          : eight DIP bytes, byte n at [8n+7:8n]
//   core_reset   : reset to the game core
//   rom_loaded, wave_loaded, dl_error : status flags
// Optional feature macro: WAVE_DL_EN (wave download + wave_loaded gating).
module dl_reset_ctrl
    import dl_reset_ctrl_pkg::*;
#(
    parameter logic [17:0] ROM_BYTES   = 18'h3_0000,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic           clk_sys,
    input  logic           reset,
    dl_reset_ctrl_if.slave ioctl,
    input  logic           user_reset,
    output logic [17:0]    dl_addr,
    output logic [7:0]     dl_data,
    output logic           dl_wr,
    output logic [19:0]    wave_addr,
    output logic [7:0]     wave_data,
    output logic           wave_wr,
    output logic [63:0]    dip,
    output logic           core_reset,
    output logic           rom_loaded,
    output logic           wave_loaded,
    output logic           dl_error
);

    state_t      r_state;
    logic        r_dl_prev;
    logic [17:0] r_count;
    logic [17:0] r_dl_addr;
    logic [7:0]  r_dl_data;
    logic        r_dl_wr;
    logic [63:0] r_dip;
    logic        r_core_reset;
    logic        r_rom_loaded;
    logic        r_dl_error;

    logic w_rise, w_fall, w_rom_start, w_rom_in_range, w_rom_ok, w_dip_wr;
    logic w_wave_loaded, w_wave_release, w_rom_release, w_hold_load, w_hold_done;

    assign w_rise         = ioctl.ioctl_download & ~r_dl_prev;
    assign w_fall         = ~ioctl.ioctl_download & r_dl_prev;
    assign w_rom_start    = w_rise && (ioctl.ioctl_index == IDX_ROM);
    assign w_rom_in_range = ioctl.ioctl_addr < {7'd0, ROM_BYTES};
    assign w_rom_ok       = (r_count == ROM_BYTES);
    assign w_dip_wr       = (ioctl.ioctl_index == IDX_DIP) && ioctl.ioctl_wr
                            && (ioctl.ioctl_addr[24:3] == '0);

`ifdef WAVE_DL_EN
    logic        r_wave_wr;
    logic [19:0] r_wave_addr;
    logic [7:0]  r_wave_data;
    logic        r_wave_loaded;
    logic        w_wave_start;

    assign w_wave_start   = w_rise && (ioctl.ioctl_index == IDX_WAVE);
    assign w_wave_loaded  = r_wave_loaded;
    assign w_wave_release = (r_state == ST_WAVE_LOAD) && w_fall && r_rom_loaded;
    assign wave_wr        = r_wave_wr;
    assign wave_addr      = r_wave_addr;
    assign wave_data      = r_wave_data;
`else
    assign w_wave_loaded  = 1'b1;
    assign w_wave_release = 1'b0;
    assign wave_wr        = 1'b0;
    assign wave_addr      = '0;
    assign wave_data      = '0;
`endif

    // Stretch load must coincide with the edge that enters HOLD, so it is
    // decoded combinationally from the same conditions the FSM uses.
    assign w_rom_release = (r_state == ST_ROM_LOAD) && w_fall && w_rom_ok && w_wave_loaded;
    assign w_hold_load   = w_rom_release || w_wave_release
                           || ((r_state == ST_HOLD) && user_reset);

    reset_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_stretch (
        .i_clk  (clk_sys),
        .i_rst  (reset),
        .i_load (w_hold_load),
        .o_done (w_hold_done)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            // Pretend a transfer was already active so one still running
            // across reset is not mistaken for a fresh rising edge.
            r_dl_prev    <= 1'b1;
            r_count      <= '0;
            r_dl_addr    <= '0;
            r_dl_data    <= '0;
            r_dl_wr      <= 1'b0;
            r_dip        <= '0;
            r_core_reset <= 1'b1;
            r_rom_loaded <= 1'b0;
            r_dl_error   <= 1'b0;
`ifdef WAVE_DL_EN
            r_wave_wr     <= 1'b0;
            r_wave_addr   <= '0;
            r_wave_data   <= '0;
            r_wave_loaded <= 1'b0;
`endif
        end else begin
            r_dl_prev    <= ioctl.ioctl_download;
            r_dl_wr      <= 1'b0;
            r_core_reset <= 1'b1;
`ifdef WAVE_DL_EN
            r_wave_wr    <= 1'b0;
`endif
            if (w_dip_wr) begin
                r_dip[{ioctl.ioctl_addr[2:0], 3'b000} +: 8] <= ioctl.ioctl_dout;
            end

            if (w_rom_start) begin
                r_state      <= ST_ROM_LOAD;
                r_count      <= '0;
                r_rom_loaded <= 1'b0;
                r_dl_error   <= 1'b0;
`ifdef WAVE_DL_EN
            end else if (w_wave_start) begin
                r_state       <= ST_WAVE_LOAD;
                r_wave_loaded <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_EMPTY: ;
                    ST_ROM_LOAD: begin
                        if (w_fall) begin
                            if (w_rom_ok) begin
                                r_rom_loaded <= 1'b1;
                                r_state      <= w_wave_loaded ? ST_HOLD : ST_EMPTY;
                            end else begin
                                r_dl_error <= 1'b1;
                                r_state    <= ST_EMPTY;
                            end
                        end else if (ioctl.ioctl_wr && w_rom_in_range) begin
                            r_dl_wr   <= 1'b1;
                            r_dl_addr <= ioctl.ioctl_addr[17:0];
                            r_dl_data <= ioctl.ioctl_dout;
                            r_count   <= r_count + 18'd1;
                        end
                    end
`ifdef WAVE_DL_EN
                    ST_WAVE_LOAD: begin
                        if (w_fall) begin
                            r_wave_loaded <= 1'b1;
                            r_state       <= r_rom_loaded ? ST_HOLD : ST_EMPTY;
                        end else if (ioctl.ioctl_wr) begin
                            r_wave_wr   <= 1'b1;
                            r_wave_addr <= ioctl.ioctl_addr[19:0];
                            r_wave_data <= ioctl.ioctl_dout;
                        end
                    end
`endif
                    ST_HOLD: begin
                        if (!user_reset && w_hold_done) begin
                            r_state      <= ST_RUN;
                            r_core_reset <= 1'b0;
                        end
                    end
                    ST_RUN: r_core_reset <= user_reset;
                    default: r_state <= ST_EMPTY;
                endcase
            end
        end
    end

    assign dl_addr    = r_dl_addr;
    assign dl_data    = r_dl_data;
    assign dl_wr      = r_dl_wr;
    assign dip        = r_dip;
    assign core_reset = r_core_reset;
    assign rom_loaded = r_rom_loaded;
    assign dl_error   = r_dl_error;
`ifdef WAVE_DL_EN
    assign wave_loaded = r_wave_loaded;
`else
    assign wave_loaded = 1'b1;
`endif

endmodule

// File: tb/tb_dl_reset_ctrl.sv
// tb_dl_reset_ctrl
// Self-checking bench for dl_reset_ctrl. Works with or without WAVE_DL_EN.
module tb_dl_reset_ctrl;
    import dl_reset_ctrl_pkg::*;

    localparam logic [17:0] ROMB = 18'd1200;
    localparam int unsigned HC   = 12;
`ifdef WAVE_DL_EN
    localparam logic WAVE_RST = 1'b0;
`else
    localparam logic WAVE_RST = 1'b1;
`endif

    logic        clk, reset, user_reset;
    logic [17:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wr;
    logic [19:0] wave_addr;
    logic [7:0]  wave_data;
    logic        wave_wr;
    logic [63:0] dip;
    logic        core_reset, rom_loaded, wave_loaded, dl_error;

    dl_reset_ctrl_if bus();

    dl_reset_ctrl #(.ROM_BYTES(ROMB), .HOLD_CYCLES(HC)) dut (
        .clk_sys(clk), .reset(reset), .ioctl(bus), .user_reset(user_reset),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr),
        .wave_addr(wave_addr), .wave_data(wave_data), .wave_wr(wave_wr),
        .dip(dip), .core_reset(core_reset), .rom_loaded(rom_loaded),
        .wave_loaded(wave_loaded), .dl_error(dl_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;
    logic [25:0] exp_dl[$], got_dl[$];
    logic [27:0] exp_wave[$], got_wave[$];
    logic [7:0]  dip_model[8];

    typedef struct {
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        exp_wr;
        logic [17:0] exp_addr;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t vecs[8];

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
    } dipv_t;
    dipv_t dvecs[7];

    always @(negedge clk) begin
        if (dl_wr === 1'b1) got_dl.push_back({dl_addr, dl_data});
        if (wave_wr === 1'b1) got_wave.push_back({wave_addr, wave_data});
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        @(negedge clk);
        bus.ioctl_wr = 1'b0;
        @(negedge clk);
    endtask

    // Reference: a ROM byte reaches the core only if its address is in range.
    task automatic wr_rom(input logic [24:0] a, input logic [7:0] d);
        if (a < {7'd0, ROMB}) exp_dl.push_back({a[17:0], d});
        wr_byte(a, d);
    endtask

    task automatic full_rom_load();
        logic [24:0] oa;
        for (int unsigned a = 0; a < ROMB; a++) begin
            if ($urandom_range(0, 5) == 0) begin
                oa = ($urandom_range(0, 1) == 0) ? 25'h30000
                                                 : {7'd0, ROMB} + 25'($urandom_range(0, 5000));
                wr_rom(oa, 8'($urandom_range(0, 255)));
            end
            wr_rom(25'(a), 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic compare_dl(input string name);
        int bad = 0;
        check({name, "_count"}, 64'(got_dl.size()), 64'(exp_dl.size()));
        for (int i = 0; i < exp_dl.size(); i++)
            if (i >= got_dl.size() || got_dl[i] !== exp_dl[i]) bad++;
        check({name, "_bytes_bad"}, 64'(bad), 64'd0);
        got_dl.delete();
        exp_dl.delete();
    endtask

    task automatic compare_wave(input string name);
        int bad = 0;
        check({name, "_count"}, 64'(got_wave.size()), 64'(exp_wave.size()));
        for (int i = 0; i < exp_wave.size(); i++)
            if (i >= got_wave.size() || got_wave[i] !== exp_wave[i]) bad++;
        check({name, "_bytes_bad"}, 64'(bad), 64'd0);
        got_wave.delete();
        exp_wave.delete();
    endtask

    // Negedges until core_reset is seen low, counted from the call.
    task automatic measure(input logic drop_user, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop_user) user_reset = 1'b0;
        end while (core_reset !== 1'b0 && n < 200);
    endtask

    function automatic logic [63:0] dip_packed();
        logic [63:0] v;
        for (int unsigned k = 0; k < 8; k++) v[k*8 +: 8] = dip_model[k];
        return v;
    endfunction

    int n;

    initial begin
        vecs[0] = '{1'b1, 25'd5,             8'hAA, 1'b1, 18'd5,    8'hAA};
        vecs[1] = '{1'b0, 25'd0,             8'h00, 1'b0, 18'd5,    8'hAA};
        vecs[2] = '{1'b1, {7'd0, ROMB},      8'h11, 1'b0, 18'd5,    8'hAA};
        vecs[3] = '{1'b1, 25'h30000,         8'h22, 1'b0, 18'd5,    8'hAA};
        vecs[4] = '{1'b1, 25'd1199,          8'h33, 1'b1, 18'd1199, 8'h33};
        vecs[5] = '{1'b1, 25'h1FFFFFF,       8'h44, 1'b0, 18'd1199, 8'h33};
        vecs[6] = '{1'b1, 25'd0,             8'h3C, 1'b1, 18'd0,    8'h3C};
        vecs[7] = '{1'b1, 25'h40007,         8'h55, 1'b0, 18'd0,    8'h3C};

        dvecs[0] = '{25'd3,       8'h5A};
        dvecs[1] = '{25'd0,       8'h11};
        dvecs[2] = '{25'd7,       8'hF0};
        dvecs[3] = '{25'd8,       8'h99};
        dvecs[4] = '{25'h100003,  8'h77};
        dvecs[5] = '{25'd5,       8'hC3};
        dvecs[6] = '{25'd0,       8'h6E};
        for (int unsigned k = 0; k < 8; k++) dip_model[k] = 8'h00;

        reset = 1'b1;
        user_reset = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index = 8'd0;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_dout = '0;
        repeat (2) @(negedge clk);

        check("rst_dl_wr", 64'(dl_wr), 64'd0);
        check("rst_dl_addr", 64'(dl_addr), 64'd0);
        check("rst_dl_data", 64'(dl_data), 64'd0);
        check("rst_wave_wr", 64'(wave_wr), 64'd0);
        check("rst_wave_addr", 64'(wave_addr), 64'd0);
        check("rst_dip", dip, 64'd0);
        check("rst_rom_loaded", 64'(rom_loaded), 64'd0);
        check("rst_wave_loaded", 64'(wave_loaded), 64'(WAVE_RST));
        check("rst_dl_error", 64'(dl_error), 64'd0);
        check("rst_core_reset", 64'(core_reset), 64'd1);

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_core_reset", 64'(core_reset), 64'd1);

        // Per-cycle ROM write vectors, one cycle of latency.
        start_dl(IDX_ROM);
        for (int i = 0; i < 8; i++) begin
            bus.ioctl_wr   = vecs[i].wr;
            bus.ioctl_addr = vecs[i].addr;
            bus.ioctl_dout = vecs[i].dout;
            @(negedge clk);
            check($sformatf("vec%0d_dl_wr", i), 64'(dl_wr), 64'(vecs[i].exp_wr));
            check($sformatf("vec%0d_dl_addr", i), 64'(dl_addr), 64'(vecs[i].exp_addr));
            check($sformatf("vec%0d_dl_data", i), 64'(dl_data), 64'(vecs[i].exp_data));
        end
        bus.ioctl_wr = 1'b0;
        @(negedge clk);
        end_dl();
        check("vec_pulses", 64'(got_dl.size()), 64'd3);
        got_dl.delete();
        check("vec_dl_error", 64'(dl_error), 64'd1);
        check("vec_rom_loaded", 64'(rom_loaded), 64'd0);
        check("vec_core_reset", 64'(core_reset), 64'd1);

        // Short ROM: 1000 of 1200 bytes.
        start_dl(IDX_ROM);
        for (int unsigned a = 0; a < 1000; a++) wr_rom(25'(a), 8'($urandom_range(0, 255)));
        end_dl();
        compare_dl("short");
        check("short_dl_error", 64'(dl_error), 64'd1);
        check("short_rom_loaded", 64'(rom_loaded), 64'd0);
        repeat (30) @(negedge clk);
        check("short_core_reset", 64'(core_reset), 64'd1);

        // Reset at byte 500 with the transfer still active.
        start_dl(IDX_ROM);
        for (int unsigned a = 0; a < 500; a++) wr_rom(25'(a), 8'($urandom_range(0, 255)));
        @(posedge clk);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        check("abort_dl_error", 64'(dl_error), 64'd0);
        check("abort_core_reset", 64'(core_reset), 64'd1);
        for (int unsigned a = 500; a < 550; a++) wr_byte(25'(a), 8'($urandom_range(0, 255)));
        end_dl();
        compare_dl("abort");
        check("abort_end_dl_error", 64'(dl_error), 64'd0);
        check("abort_end_rom_loaded", 64'(rom_loaded), 64'd0);

        // Full ROM with out-of-range noise writes.
        start_dl(IDX_ROM);
        full_rom_load();
`ifdef WAVE_DL_EN
        end_dl();
        compare_dl("full");
        check("full_rom_loaded", 64'(rom_loaded), 64'd1);
        check("full_dl_error", 64'(dl_error), 64'd0);
        check("full_wave_loaded", 64'(wave_loaded), 64'd0);
        repeat (HC + 4) @(negedge clk);
        check("full_wait_core_reset", 64'(core_reset), 64'd1);
        start_dl(IDX_WAVE);
        for (int i = 0; i < 40; i++) begin
            logic [24:0] wa;
            logic [7:0]  wd;
            wa = 25'($urandom_range(0, 32'h1FFFFFF));
            wd = 8'($urandom_range(0, 255));
            exp_wave.push_back({wa[19:0], wd});
            wr_byte(wa, wd);
        end
        bus.ioctl_download = 1'b0;
        measure(1'b0, n);
        check("wave_release_cycles", 64'(n), 64'(HC + 1));
        compare_wave("wave");
        check("wave_wave_loaded", 64'(wave_loaded), 64'd1);
        check("wave_rom_loaded", 64'(rom_loaded), 64'd1);
`else
        bus.ioctl_download = 1'b0;
        measure(1'b0, n);
        check("rom_release_cycles", 64'(n), 64'(HC + 1));
        compare_dl("full");
        check("full_rom_loaded", 64'(rom_loaded), 64'd1);
        check("full_dl_error", 64'(dl_error), 64'd0);
`endif

        // DIP writes while running.
        start_dl(IDX_DIP);
        check("dip_start_core_reset", 64'(core_reset), 64'd0);
        for (int i = 0; i < 7; i++) begin
            if (dvecs[i].addr < 25'd8) dip_model[dvecs[i].addr[2:0]] = dvecs[i].data;
            wr_byte(dvecs[i].addr, dvecs[i].data);
            check($sformatf("dip%0d_value", i), dip, dip_packed());
            check($sformatf("dip%0d_core_reset", i), 64'(core_reset), 64'd0);
        end
        end_dl();
        check("dip_byte3", 64'(dip[31:24]), 64'h5A);
        check("dip_end_core_reset", 64'(core_reset), 64'd0);

        // core_reset follows user_reset in RUN.
        user_reset = 1'b1;
        @(negedge clk);
        check("run_user_reset_hi", 64'(core_reset), 64'd1);
        user_reset = 1'b0;
        @(negedge clk);
        check("run_user_reset_lo", 64'(core_reset), 64'd0);

`ifndef WAVE_DL_EN
        // Index 2 is inert without the wave feature.
        start_dl(IDX_WAVE);
        for (int i = 0; i < 20; i++)
            wr_byte(25'($urandom_range(0, 32'hFFFFF)), 8'($urandom_range(0, 255)));
        check("idx2_core_reset", 64'(core_reset), 64'd0);
        end_dl();
        check("idx2_end_core_reset", 64'(core_reset), 64'd0);
`endif

        // New ROM from RUN, then user_reset during HOLD restarts the stretch.
        start_dl(IDX_ROM);
        check("reload_core_reset", 64'(core_reset), 64'd1);
        check("reload_rom_loaded", 64'(rom_loaded), 64'd0);
        full_rom_load();
        bus.ioctl_download = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_core_reset", 64'(core_reset), 64'd1);
        user_reset = 1'b1;
        measure(1'b1, n);
        check("hold_reload_cycles", 64'(n), 64'(HC + 1));
        compare_dl("reload");
        check("reload_end_rom_loaded", 64'(rom_loaded), 64'd1);
        check("reload_end_dl_error", 64'(dl_error), 64'd0);

        compare_wave("wave_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
